// File: rtl/m_mig_app_responder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : m_mig_app_responder_if
// Description : MIG 7-series user (app_*) interface bundle. The master side
//               is the DRAM test driver; the slave side is the responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface m_mig_app_responder_if #(
  parameter int APP_ADDR_WIDTH = 29,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16
);
  // Command channel
  logic [APP_ADDR_WIDTH-1:0] app_addr;
  logic [2:0]                app_cmd;
  logic                      app_en;
  logic                      app_rdy;
  // Write-data channel
  logic [APP_DATA_WIDTH-1:0] app_wdf_data;
  logic [APP_MASK_WIDTH-1:0] app_wdf_mask;
  logic                      app_wdf_wren;
  logic                      app_wdf_end;
  logic                      app_wdf_rdy;
  // Read-data channel and status
  logic [APP_DATA_WIDTH-1:0] app_rd_data;
  logic                      app_rd_data_valid;
  logic                      app_rd_data_end;
  logic                      init_calib_complete;
  logic                      proto_err;

  modport master (
    output app_addr, app_cmd, app_en,
    output app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy,
    input  app_rd_data, app_rd_data_valid, app_rd_data_end,
    input  init_calib_complete, proto_err
  );

  modport slave (
    input  app_addr, app_cmd, app_en,
    input  app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy,
    output app_rd_data, app_rd_data_valid, app_rd_data_end,
    output init_calib_complete, proto_err
  );
endinterface
`default_nettype wire

// File: rtl/m_mig_app_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : m_mig_app_responder
// Description : Cycle-level stand-in for mig_7series_0 on the app_* user
//               interface. Queues commands and write data, executes one
//               command per cycle in order against an internal memory and
//               returns read data after a fixed pipeline latency.
//               Optional macro MIG_RESP_BACKPRESSURE_EN adds LFSR-driven
//               pseudo-random deassertion of app_rdy / app_wdf_rdy.
// Revision    : 1.0 - initial release
// ============================================================================
module m_mig_app_responder #(
  parameter int APP_ADDR_WIDTH = 29,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16,
  parameter int MEM_ADDR_BITS  = 10,
  parameter int QUEUE_DEPTH    = 4,
  parameter int RD_LATENCY     = 8,
  parameter int CALIB_CYCLES   = 64
) (
  input  wire logic             w_clk,
  input  wire logic             sys_rst,
  m_mig_app_responder_if.slave  app
);

  localparam int c_qptr_w = $clog2(QUEUE_DEPTH);
  localparam int c_qcnt_w = $clog2(QUEUE_DEPTH + 1);
  localparam int c_cal_w  = $clog2(CALIB_CYCLES + 1);
  localparam int c_cmd_w  = 3 + MEM_ADDR_BITS;
  localparam int c_wdf_w  = APP_MASK_WIDTH + APP_DATA_WIDTH;

  localparam logic [2:0]          c_cmd_write = 3'b000;
  localparam logic [2:0]          c_cmd_read  = 3'b001;
  localparam logic [c_qcnt_w-1:0] c_q_full    = c_qcnt_w'(QUEUE_DEPTH);
  localparam logic [c_qcnt_w-1:0] c_q_one     = c_qcnt_w'(1);
  localparam logic [c_cal_w-1:0]  c_cal_last  = c_cal_w'(CALIB_CYCLES - 1);

  typedef enum logic [0:0] {
    S_CALIB = 1'b0,
    S_EXEC  = 1'b1
  } state_t;

  // Control state and registered handshake outputs
  state_t               r_state;
  logic [c_cal_w-1:0]   r_calib_cnt;
  logic                 r_calib;
  logic                 r_app_rdy;
  logic                 r_wdf_rdy;
  logic                 r_proto_err;

  // Command queue: {cmd, memory index}
  logic [c_cmd_w-1:0]   r_cmd_q [QUEUE_DEPTH];
  logic [c_qptr_w-1:0]  r_cmd_wr;
  logic [c_qptr_w-1:0]  r_cmd_rd;
  logic [c_qcnt_w-1:0]  r_cmd_cnt;

  // Write-data queue: {mask, data}
  logic [c_wdf_w-1:0]   r_wdf_q [QUEUE_DEPTH];
  logic [c_qptr_w-1:0]  r_wdf_wr;
  logic [c_qptr_w-1:0]  r_wdf_rd;
  logic [c_qcnt_w-1:0]  r_wdf_cnt;

  // Backing memory and read-return pipeline
  logic [APP_DATA_WIDTH-1:0]                  r_mem [2**MEM_ADDR_BITS];
  logic [RD_LATENCY-1:0]                      r_rd_vld;
  logic [RD_LATENCY-1:0][APP_DATA_WIDTH-1:0]  r_rd_data;

  // Combinational datapath
  logic                       w_cmd_push;
  logic                       w_wdf_push;
  logic                       w_wdf_end_err;
  logic [c_cmd_w-1:0]         w_head;
  logic [2:0]                 w_head_cmd;
  logic [MEM_ADDR_BITS-1:0]   w_head_idx;
  logic [c_wdf_w-1:0]         w_wdf_head;
  logic [APP_MASK_WIDTH-1:0]  w_wdf_head_mask;
  logic [APP_DATA_WIDTH-1:0]  w_wdf_head_data;
  logic                       w_exec_ok;
  logic                       w_exec_rd;
  logic                       w_exec_wr;
  logic                       w_exec_bad;
  logic                       w_cmd_pop;
  logic                       w_wdf_pop;
  logic [c_qcnt_w-1:0]        w_cmd_cnt_nxt;
  logic [c_qcnt_w-1:0]        w_wdf_cnt_nxt;
  logic                       w_calib_nxt;
  logic                       w_bp_cmd_ok;
  logic                       w_bp_wdf_ok;
  logic                       w_unused_addr;

  // Address bits below burst granularity and above the memory size alias away
  assign w_unused_addr = ^{app.app_addr[2:0], app.app_addr[APP_ADDR_WIDTH-1:MEM_ADDR_BITS+3]};

  assign w_cmd_push    = app.app_en & r_app_rdy;
  assign w_wdf_push    = app.app_wdf_wren & r_wdf_rdy;
  assign w_wdf_end_err = w_wdf_push & (app.app_wdf_end != app.app_wdf_wren);

  assign w_head          = r_cmd_q[r_cmd_rd];
  assign w_head_cmd      = w_head[c_cmd_w-1 -: 3];
  assign w_head_idx      = w_head[MEM_ADDR_BITS-1:0];
  assign w_wdf_head      = r_wdf_q[r_wdf_rd];
  assign w_wdf_head_mask = w_wdf_head[c_wdf_w-1 -: APP_MASK_WIDTH];
  assign w_wdf_head_data = w_wdf_head[APP_DATA_WIDTH-1:0];

  // Executor: the head command retires this cycle unless it is a WRITE still
  // waiting for its data beat. Reset blocks execution in its own cycle.
  assign w_exec_ok  = !sys_rst && (r_state == S_EXEC) && (r_cmd_cnt != '0);
  assign w_exec_rd  = w_exec_ok && (w_head_cmd == c_cmd_read);
  assign w_exec_wr  = w_exec_ok && (w_head_cmd == c_cmd_write) && (r_wdf_cnt != '0);
  assign w_exec_bad = w_exec_ok && (w_head_cmd != c_cmd_read) && (w_head_cmd != c_cmd_write);
  assign w_cmd_pop  = w_exec_rd | w_exec_wr | w_exec_bad;
  assign w_wdf_pop  = w_exec_wr;

  assign w_calib_nxt = (r_state == S_EXEC) || (r_calib_cnt == c_cal_last);

  // Next occupancy of both queues, used for the registered ready flags
  always_comb begin
    w_cmd_cnt_nxt = r_cmd_cnt;
    w_wdf_cnt_nxt = r_wdf_cnt;
    if (w_cmd_push && !w_cmd_pop)
      w_cmd_cnt_nxt = r_cmd_cnt + c_q_one;
    else if (!w_cmd_push && w_cmd_pop)
      w_cmd_cnt_nxt = r_cmd_cnt - c_q_one;
    if (w_wdf_push && !w_wdf_pop)
      w_wdf_cnt_nxt = r_wdf_cnt + c_q_one;
    else if (!w_wdf_push && w_wdf_pop)
      w_wdf_cnt_nxt = r_wdf_cnt - c_q_one;
  end

`ifdef MIG_RESP_BACKPRESSURE_EN
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_nxt;

  assign w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

  // Free-running LFSR; the ready flags use the value that will be current next cycle
  always_ff @(posedge w_clk) begin
    if (sys_rst) r_lfsr <= 16'hACE1;
    else         r_lfsr <= w_lfsr_nxt;
  end

  assign w_bp_cmd_ok = (w_lfsr_nxt[1:0] != 2'b00);
  assign w_bp_wdf_ok = (w_lfsr_nxt[3:2] != 2'b00);
`else
  assign w_bp_cmd_ok = 1'b1;
  assign w_bp_wdf_ok = 1'b1;
`endif

  // Calibration FSM plus registered ready flags and sticky protocol error
  always_ff @(posedge w_clk) begin
    if (sys_rst) begin
      r_state     <= S_CALIB;
      r_calib_cnt <= '0;
      r_calib     <= 1'b0;
      r_app_rdy   <= 1'b0;
      r_wdf_rdy   <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      case (r_state)
        S_CALIB: begin
          if (r_calib_cnt == c_cal_last) begin
            r_state <= S_EXEC;
            r_calib <= 1'b1;
          end else begin
            r_calib_cnt <= r_calib_cnt + 1'b1;
          end
        end
        S_EXEC:  r_state <= S_EXEC;
        default: r_state <= S_CALIB;
      endcase
      r_app_rdy <= w_calib_nxt && (w_cmd_cnt_nxt != c_q_full) && w_bp_cmd_ok;
      r_wdf_rdy <= w_calib_nxt && (w_wdf_cnt_nxt != c_q_full) && w_bp_wdf_ok;
      if (w_exec_bad || w_wdf_end_err)
        r_proto_err <= 1'b1;
    end
  end

  // Command queue pointers and occupancy
  always_ff @(posedge w_clk) begin
    if (sys_rst) begin
      r_cmd_wr  <= '0;
      r_cmd_rd  <= '0;
      r_cmd_cnt <= '0;
    end else begin
      if (w_cmd_push) r_cmd_wr <= r_cmd_wr + 1'b1;
      if (w_cmd_pop)  r_cmd_rd <= r_cmd_rd + 1'b1;
      r_cmd_cnt <= w_cmd_cnt_nxt;
    end
  end

  // Command queue storage; only the memory index is kept from the address
  always_ff @(posedge w_clk) begin
    if (w_cmd_push)
      r_cmd_q[r_cmd_wr] <= {app.app_cmd, app.app_addr[MEM_ADDR_BITS+2:3]};
  end

  // Write-data queue pointers and occupancy
  always_ff @(posedge w_clk) begin
    if (sys_rst) begin
      r_wdf_wr  <= '0;
      r_wdf_rd  <= '0;
      r_wdf_cnt <= '0;
    end else begin
      if (w_wdf_push) r_wdf_wr <= r_wdf_wr + 1'b1;
      if (w_wdf_pop)  r_wdf_rd <= r_wdf_rd + 1'b1;
      r_wdf_cnt <= w_wdf_cnt_nxt;
    end
  end

  // Write-data queue storage
  always_ff @(posedge w_clk) begin
    if (w_wdf_push)
      r_wdf_q[r_wdf_wr] <= {app.app_wdf_mask, app.app_wdf_data};
  end

  // Byte-masked memory write; contents deliberately survive sys_rst
  always_ff @(posedge w_clk) begin
    if (w_exec_wr) begin
      for (int b = 0; b < APP_MASK_WIDTH; b++) begin
        if (!w_wdf_head_mask[b])
          r_mem[w_head_idx][b*8 +: 8] <= w_wdf_head_data[b*8 +: 8];
      end
    end
  end

  // Non-stalling read-return pipeline; reset discards in-flight reads
  always_ff @(posedge w_clk) begin
    if (sys_rst) begin
      r_rd_vld  <= '0;
      r_rd_data <= '0;
    end else begin
      r_rd_vld  <= {r_rd_vld[RD_LATENCY-2:0], w_exec_rd};
      r_rd_data <= {r_rd_data[RD_LATENCY-2:0],
                    (w_exec_rd ? r_mem[w_head_idx] : {APP_DATA_WIDTH{1'b0}})};
    end
  end

  assign app.app_rdy             = r_app_rdy;
  assign app.app_wdf_rdy         = r_wdf_rdy;
  assign app.app_rd_data         = r_rd_data[RD_LATENCY-1];
  assign app.app_rd_data_valid   = r_rd_vld[RD_LATENCY-1];
  assign app.app_rd_data_end     = r_rd_vld[RD_LATENCY-1];
  assign app.init_calib_complete = r_calib;
  assign app.proto_err           = r_proto_err;

endmodule
`default_nettype wire
